// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - registered, handshaked ALU control sequencer with mult/div start/done and timeout
module alu_op_sequencer #(
  parameter int TIMEOUT = 34,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [4:0] controlType,
  input  logic       save_en,
  input  logic       div_zero,
  input  logic       md_done,
  output logic       md_start,
  output logic [2:0] ALUOp,
  output logic [2:0] SrcOut,
  output logic [1:0] StoreMD,
  output logic       divOp,
  output logic       multOp,
  output logic       orOp,
  output logic       overflowOp,
  output logic       ALUOutSave,
  output logic [1:0] condType,
  output logic       op_done,
  output logic       op_err,
  output logic [1:0] err_code
);

  typedef enum logic [1:0] {IDLE, EXEC, MD_WAIT, MD_STORE} state_t;

  typedef struct packed {
    logic       md_start;
    logic [2:0] alu_op;
    logic [2:0] src_out;
    logic [1:0] store_md;
    logic       div_op;
    logic       mult_op;
    logic       or_op;
    logic       ovf_op;
    logic       out_save;
    logic       done;
    logic       err;
    logic [1:0] err_code;
  } ctl_t;

  localparam logic [4:0] OP_DIV  = 5'b01001;
  localparam logic [4:0] OP_MULT = 5'b01010;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctl_t             ctl_q, ctl_d;
  logic [1:0]       cond_q, cond_d;
  logic             ready_q;

  logic [2:0] dec_alu, dec_src;
  logic       dec_or, dec_ovf, dec_legal;

  always_comb begin
    dec_alu   = 3'b000;
    dec_src   = 3'b000;
    dec_or    = 1'b0;
    dec_ovf   = 1'b0;
    dec_legal = 1'b1;
    case (controlType)
      5'b00000: dec_src = 3'b011;
      5'b00001: begin dec_alu = 3'b001; dec_src = 3'b011; dec_ovf = 1'b1; end
      5'b00010: begin dec_alu = 3'b010; dec_src = 3'b011; dec_ovf = 1'b1; end
      5'b00011: begin dec_alu = 3'b011; dec_src = 3'b011; end
      5'b00100: begin dec_alu = 3'b100; dec_src = 3'b011; dec_ovf = 1'b1; end
      5'b00101: begin dec_alu = 3'b101; dec_src = 3'b011; end
      5'b00110: begin dec_alu = 3'b110; dec_src = 3'b011; end
      5'b00111: begin dec_alu = 3'b111; dec_src = 3'b010; end
      5'b01000: begin dec_or  = 1'b1;   dec_src = 3'b100; end
      5'b01011: begin dec_alu = 3'b001; dec_src = 3'b011; end
      5'b01100: dec_src = 3'b001;
      5'b01101: dec_src = 3'b000;
      5'b10010: dec_src = 3'b110;
      default:  dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    ctl_d   = '0;
    cond_d  = cond_q;
    case (state_q)
      IDLE: begin
        if (op_valid && ready_q) begin
          if (controlType == OP_MULT || (controlType == OP_DIV && !div_zero)) begin
            state_d         = MD_WAIT;
            cnt_d           = CNT_W'(1);
            ctl_d.md_start  = 1'b1;
            ctl_d.div_op    = (controlType == OP_DIV);
            ctl_d.mult_op   = (controlType == OP_MULT);
          end else begin
            state_d    = EXEC;
            ctl_d.done = 1'b1;
            if (controlType == OP_DIV) begin
              ctl_d.err      = 1'b1;
              ctl_d.err_code = 2'b01;
            end else if (controlType >= 5'b01110 && controlType <= 5'b10001) begin
              // cond codes 01110..10001 map to condType 00..11 via their low bits + 2
              ctl_d.alu_op = 3'b111;
              cond_d       = controlType[1:0] + 2'b10;
            end else if (dec_legal) begin
              ctl_d.alu_op   = dec_alu;
              ctl_d.src_out  = dec_src;
              ctl_d.or_op    = dec_or;
              ctl_d.ovf_op   = dec_ovf;
              ctl_d.out_save = save_en;
            end else begin
              ctl_d.err      = 1'b1;
              ctl_d.err_code = 2'b11;
            end
          end
        end
      end
      MD_WAIT: begin
        // md_done on the expiry cycle still completes normally
        if (md_done) begin
          state_d        = MD_STORE;
          ctl_d.done     = 1'b1;
          ctl_d.store_md = ctl_q.div_op ? 2'b01 : 2'b10;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d        = EXEC;
          ctl_d.done     = 1'b1;
          ctl_d.err      = 1'b1;
          ctl_d.err_code = 2'b10;
        end else begin
          cnt_d         = cnt_q + 1'b1;
          ctl_d.div_op  = ctl_q.div_op;
          ctl_d.mult_op = ctl_q.mult_op;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctl_q   <= '0;
      cond_q  <= 2'b00;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      cond_q  <= cond_d;
      ready_q <= (state_d == IDLE);
    end
  end

  assign op_ready   = ready_q;
  assign md_start   = ctl_q.md_start;
  assign ALUOp      = ctl_q.alu_op;
  assign SrcOut     = ctl_q.src_out;
  assign StoreMD    = ctl_q.store_md;
  assign divOp      = ctl_q.div_op;
  assign multOp     = ctl_q.mult_op;
  assign orOp       = ctl_q.or_op;
  assign overflowOp = ctl_q.ovf_op;
  assign ALUOutSave = ctl_q.out_save;
  assign condType   = cond_q;
  assign op_done    = ctl_q.done;
  assign op_err     = ctl_q.err;
  assign err_code   = ctl_q.err_code;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized + directed bench for alu_op_sequencer against a transaction-level model
module tb_alu_op_sequencer;
  localparam int TIMEOUT = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0, op_valid = 1'b0, save_en = 1'b0, div_zero = 1'b0, md_done = 1'b0;
  logic [4:0] controlType = 5'd0;
  logic       op_ready, md_start, divOp, multOp, orOp, overflowOp, ALUOutSave, op_done, op_err;
  logic [2:0] ALUOp, SrcOut;
  logic [1:0] StoreMD, condType, err_code;

  alu_op_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .controlType(controlType), .save_en(save_en), .div_zero(div_zero), .md_done(md_done),
    .md_start(md_start), .ALUOp(ALUOp), .SrcOut(SrcOut), .StoreMD(StoreMD),
    .divOp(divOp), .multOp(multOp), .orOp(orOp), .overflowOp(overflowOp),
    .ALUOutSave(ALUOutSave), .condType(condType), .op_done(op_done), .op_err(op_err),
    .err_code(err_code)
  );

  typedef struct packed {
    logic       rdy;
    logic       start;
    logic [2:0] alu;
    logic [2:0] src;
    logic [1:0] store;
    logic       div;
    logic       mult;
    logic       orop;
    logic       ovf;
    logic       save;
    logic [1:0] cond;
    logic       done;
    logic       err;
    logic [1:0] ecode;
  } vec_t;

  vec_t act;
  assign act = {op_ready, md_start, ALUOp, SrcOut, StoreMD, divOp, multOp, orOp, overflowOp,
                ALUOutSave, condType, op_done, op_err, err_code};

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t expq[$];
  logic [1:0] cur_cond = 2'b00;

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      vec_t e;
      e = expq.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL cycle_check t=%0t: got %b want %b", $time, act, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic vec_t idle_vec();
    vec_t v = '0;
    v.rdy  = 1'b1;
    v.cond = cur_cond;
    return v;
  endfunction

  function automatic vec_t wait_vec(input logic first, input logic is_div);
    vec_t v = '0;
    v.start = first;
    v.div   = is_div;
    v.mult  = !is_div;
    v.cond  = cur_cond;
    return v;
  endfunction

  // Code map from the decoder table; cur_cond must already reflect any cond-code update
  function automatic vec_t exec_vec(input logic [4:0] code, input logic sv, input logic dz);
    vec_t v = '0;
    v.cond = cur_cond;
    v.done = 1'b1;
    if (code == 5'd9 && dz) begin
      v.err = 1'b1; v.ecode = 2'd1;
    end else if (code >= 5'd14 && code <= 5'd17) begin
      v.alu = 3'd7;
    end else if (code >= 5'd19) begin
      v.err = 1'b1; v.ecode = 2'd3;
    end else begin
      v.save = sv;
      case (code)
        5'd0:  v.src = 3'd3;
        5'd1:  begin v.alu = 3'd1; v.src = 3'd3; v.ovf = 1'b1; end
        5'd2:  begin v.alu = 3'd2; v.src = 3'd3; v.ovf = 1'b1; end
        5'd3:  begin v.alu = 3'd3; v.src = 3'd3; end
        5'd4:  begin v.alu = 3'd4; v.src = 3'd3; v.ovf = 1'b1; end
        5'd5:  begin v.alu = 3'd5; v.src = 3'd3; end
        5'd6:  begin v.alu = 3'd6; v.src = 3'd3; end
        5'd7:  begin v.alu = 3'd7; v.src = 3'd2; end
        5'd8:  begin v.orop = 1'b1; v.src = 3'd4; end
        5'd11: begin v.alu = 3'd1; v.src = 3'd3; end
        5'd12: v.src = 3'd1;
        5'd13: v.src = 3'd0;
        5'd18: v.src = 3'd6;
        default: v.src = 3'd0;
      endcase
    end
    return v;
  endfunction

  task automatic step(input vec_t e);
    expq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic noise();
    op_valid    = 1'($urandom_range(0, 1));
    controlType = 5'($urandom_range(0, 31));
    save_en     = 1'($urandom_range(0, 1));
    div_zero    = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      noise();
      op_valid = 1'b0;
      md_done  = 1'($urandom_range(0, 1));
      step(idle_vec());
    end
  endtask

  // d = wait cycle in which md_done pulses; d > TIMEOUT means it never comes
  task automatic run_op(input logic [4:0] code, input logic sv, input logic dz, input int d,
                        output vec_t dv, output int starts, output int mdcyc);
    vec_t v;
    starts = 0; mdcyc = 0; dv = '0;
    op_valid = 1'b1; controlType = code; save_en = sv; div_zero = dz;
    md_done  = 1'($urandom_range(0, 1));
    if (code == 5'd10 || (code == 5'd9 && !dz)) begin
      step(wait_vec(1'b1, code == 5'd9));
      starts += int'(act.start); mdcyc += int'(act.div | act.mult);
      for (int k = 1; k <= TIMEOUT; k++) begin
        noise();
        md_done = (k == d);
        if (k == d) begin
          v = '0; v.cond = cur_cond; v.done = 1'b1; v.store = (code == 5'd9) ? 2'd1 : 2'd2;
        end else if (k == TIMEOUT) begin
          v = '0; v.cond = cur_cond; v.done = 1'b1; v.err = 1'b1; v.ecode = 2'd2;
        end else begin
          v = wait_vec(1'b0, code == 5'd9);
        end
        step(v);
        starts += int'(act.start); mdcyc += int'(act.div | act.mult);
        if (v.done) begin
          dv = act;
          break;
        end
      end
    end else begin
      if (code >= 5'd14 && code <= 5'd17) cur_cond = 2'(code - 5'd14);
      step(exec_vec(code, sv, dz));
      starts += int'(act.start);
      dv = act;
    end
    noise();
    md_done = 1'($urandom_range(0, 1));
    step(idle_vec());
    op_valid = 1'b0;
  endtask

  task automatic reset_mid_wait(input logic [4:0] code, input int w);
    op_valid = 1'b1; controlType = code; div_zero = 1'b0; md_done = 1'b0;
    step(wait_vec(1'b1, code == 5'd9));
    for (int k = 1; k < w; k++) begin
      noise(); md_done = 1'b0;
      step(wait_vec(1'b0, code == 5'd9));
    end
    noise(); md_done = 1'b0; reset = 1'b0;
    cur_cond = 2'b00;
    step('0);
    chk("rst_mid_no_done", act.done, 0);
    reset = 1'b1; op_valid = 1'b0;
    step(idle_vec());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t dv, pv;
    int   st, mc, dd;
    logic [4:0] code;

    pv = exec_vec(5'd7, 1'b1, 1'b0);
    chk("pin_cmp_src", pv.src, 3'd2);
    chk("pin_cmp_alu", pv.alu, 3'd7);
    pv = exec_vec(5'd18, 1'b1, 1'b0);
    chk("pin_10010_src", pv.src, 3'd6);
    pv = exec_vec(5'd19, 1'b1, 1'b0);
    chk("pin_illegal_ecode", pv.ecode, 2'd3);

    reset = 1'b0;
    step('0);
    step('0);
    chk("reset_outputs", act, 0);
    reset = 1'b1;
    step(idle_vec());
    chk("ready_after_reset", act.rdy, 1);

    run_op(5'b00001, 1'b1, 1'b0, 0, dv, st, mc);
    chk("add_alu", dv.alu, 3'b001);
    chk("add_ovf", dv.ovf, 1);
    chk("add_src", dv.src, 3'b011);
    chk("add_save", dv.save, 1);
    chk("add_done", dv.done, 1);
    chk("add_ready_after", act.rdy, 1);

    run_op(5'b01111, 1'b1, 1'b0, 0, dv, st, mc);
    chk("cond_set", dv.cond, 2'b01);
    chk("cond_save", dv.save, 0);
    run_op(5'b00000, 1'b1, 1'b0, 0, dv, st, mc);
    chk("cond_sticky", act.cond, 2'b01);

    run_op(5'b01010, 1'b0, 1'b0, 5, dv, st, mc);
    chk("mult_starts", st, 1);
    chk("mult_cycles", mc, 5);
    chk("mult_store", dv.store, 2'b10);
    chk("mult_err", dv.err, 0);

    run_op(5'b01001, 1'b0, 1'b1, 3, dv, st, mc);
    chk("divz_starts", st, 0);
    chk("divz_ecode", {dv.done, dv.err, dv.ecode}, 4'b1101);

    run_op(5'b01001, 1'b0, 1'b0, TIMEOUT + 5, dv, st, mc);
    chk("tmo_cycles", mc, TIMEOUT);
    chk("tmo_ecode", {dv.done, dv.err, dv.ecode, dv.store}, 6'b111000);

    run_op(5'b01001, 1'b0, 1'b0, TIMEOUT, dv, st, mc);
    chk("done_wins_store", {dv.store, dv.err}, 3'b010);

    run_op(5'b11000, 1'b1, 1'b0, 0, dv, st, mc);
    chk("illegal_ecode", {dv.err, dv.ecode}, 3'b111);

    reset_mid_wait(5'b01010, 4);
    chk("rst_mid_ready", act.rdy, 1);

    for (int n = 0; n < 300; n++) begin
      idle_cycles($urandom_range(0, 2));
      if ($urandom_range(0, 29) == 0) begin
        reset_mid_wait(($urandom_range(0, 1) != 0) ? 5'd9 : 5'd10, $urandom_range(1, TIMEOUT - 1));
      end else begin
        code = ($urandom_range(0, 3) == 0) ? 5'(9 + $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
        dd   = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 8) : $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
        run_op(code, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), dd, dv, st, mc);
      end
    end

    @(posedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Registered, handshaked successor to the combinational ALU control decoder. Accepts one 5-bit ALU control code per transaction, drives the ALU/mux/HI-LO control outputs for exactly the required number of cycles, sequences multi-cycle multiply/divide through a start/done handshake with a timeout, and flags divide-by-zero and illegal codes. It sits between the main control FSM and the ALU/mult/div datapath.

## Interface
- TIMEOUT, 34: max cycles waited in MD_WAIT for md_done (≥2).
- CNT_W, $clog2(TIMEOUT+1): timeout counter width.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- op_valid  in  1  request valid.
- op_ready  out  1  high only in IDLE.
- controlType  in  5  operation code; sampled on accept.
- save_en  in  1  ALUOutSave enable (0 during branch); sampled on accept.
- div_zero  in  1  divisor==0; sampled on accept.
- md_done  in  1  mult/div unit finished (1-cycle pulse).
- md_start  out  1  1-cycle start pulse to mult/div.
- ALUOp  out  3  ALU function. SrcOut  out  3  result mux select. StoreMD  out  2  HI/LO write (01 div, 10 mult).
- divOp, multOp, orOp, overflowOp, ALUOutSave  out  1 each.
- condType  out  2  sticky branch-condition select.
- op_done  out  1  transaction complete (1-cycle pulse).
- op_err  out  1  with op_done: div-by-zero, timeout or illegal code.
- err_code  out  2  00 none, 01 div-by-zero, 10 timeout, 11 illegal.

## Operation
- States: IDLE, EXEC, MD_WAIT, MD_STORE. Accept = op_valid & op_ready.
- Decode (same code map as existing decoder): 00000 pass ALUOp000/Src011; 00001 add ALUOp001 ovf/Src011; 00010 sub ALUOp010 ovf; 00011 and 011; 00100 inc 100 ovf; 00101 not 101; 00110 xor 110 (all Src011); 00111 cmp ALUOp111 Src010; 01000 orOp Src100; 01011 add no-ovf ALUOp001 Src011; 01100 Src001; 01101 Src000; 10010 Src110. All these set ALUOutSave = save_en.
- Cond codes 01110/01111/10000/10001: ALUOp=111, condType<=00/01/10/11; ALUOutSave=0. condType changes only on cond codes, else holds.
- Single-cycle codes and cond codes: IDLE->EXEC; EXEC drives decoded outputs for one cycle with op_done=1, then IDLE.
- 01001 div / 01010 mult: IDLE->MD_WAIT; divOp/multOp held high throughout MD_WAIT; md_start=1 first MD_WAIT cycle only; counter counts MD_WAIT cycles. md_done -> MD_STORE: StoreMD=01/10, op_done=1 for one cycle, then IDLE.
- Div with div_zero=1 at accept: go to EXEC, no md_start, all controls 0, op_done=1, op_err=1, err_code=01.
- Timeout: counter reaches TIMEOUT without md_done -> op_done=1, op_err=1, err_code=10, StoreMD=0 that cycle, then IDLE.
- Codes 10011–11111: EXEC with all controls 0, op_err=1, err_code=11.

## Timing
- Reset (reset==0 at edge): state IDLE, every output 0 (op_ready goes 1 the cycle after reset deasserts), condType=00, counter 0. Reset mid-MD_WAIT abandons op; no op_done.
- Outputs are registered: accept at edge T, controls valid T+1.
- Single-cycle latency 1, throughput one op per 2 cycles.
- MD latency = cycles to md_done + 1; op_done one cycle after md_done sample.
- md_done in same cycle as timeout expiry: done wins (MD_STORE, no error).
- md_done outside MD_WAIT ignored. op_valid while busy ignored (not queued).
- op_err/err_code valid only when op_done=1, else 0.

## Test plan
- Reset with reset=0 two cycles -> all outputs 0, condType=00; release -> op_ready=1.
- Accept 00001, save_en=1 -> next cycle ALUOp=001, overflowOp=1, SrcOut=011, ALUOutSave=1, op_done=1; then op_ready=1.
- Accept 01111 then 00000 -> condType=01 and stays 01 after the 00000 op.
- Accept 01010, md_done after 5 cycles -> md_start single pulse, multOp high 5 cycles, then StoreMD=10 with op_done=1, op_err=0.
- Accept 01001 with div_zero=1 -> no md_start, op_done=1, err_code=01; accept 01001, never md_done -> op_done at TIMEOUT, err_code=10.
- Accept 11000 -> op_err=1, err_code=11; reset asserted mid-MD_WAIT -> IDLE, no op_done.
